// File: rtl/motor_pkg.sv
// Shared types for the two-motor H-bridge PWM driver: command, direction and channel state.
package motor_pkg;

    typedef enum logic [2:0] {STOP, FORWARD, BACKWARD, LEFT, RIGHT} cmd_t;
    typedef enum logic [1:0] {OFF, FWD, REV} dir_t;
    typedef enum logic [1:0] {IDLE, ACTIVE, DECEL, DEAD} ch_state_t;

    // Anything that is not exactly one-hot is treated as a stop request.
    function automatic cmd_t decode_cmd(input logic [3:0] fblr);
        case (fblr)
            4'b1000: return FORWARD;
            4'b0100: return BACKWARD;
            4'b0010: return LEFT;
            4'b0001: return RIGHT;
            default: return STOP;
        endcase
    endfunction

endpackage

// File: rtl/motor_drive_pwm_channel.sv
// One H-bridge channel: ramped duty, reversal dead-time and registered fwd/rev pins.
// state  | meaning
// IDLE   | both pins low, duty 0, waiting for a target direction
// ACTIVE | driving cdir, duty ramps toward tduty on each tick
// DECEL  | direction no longer wanted, duty ramps down to 0
// DEAD   | both pins low for DEAD_CYC clocks before the next direction
module motor_channel
    import motor_pkg::*;
#(
    parameter int PWM_W     = 8,
    parameter int RAMP_STEP = 1,
    parameter int DEAD_CYC  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    input  logic [1:0]       tdir,
    input  logic [PWM_W-1:0] tduty,
    input  logic [PWM_W-1:0] pcnt,
    output logic             fwd,
    output logic             rev,
    output logic [1:0]       state
);

    localparam int DW = $clog2(DEAD_CYC + 1);
    localparam logic [PWM_W:0] STEP_W    = (PWM_W+1)'(RAMP_STEP);
    localparam logic [DW-1:0]  DEAD_LOAD = DW'(DEAD_CYC);

    ch_state_t        st;
    dir_t             cdir;
    logic [PWM_W-1:0] duty;
    logic [DW-1:0]    dead_cnt;

    logic [PWM_W:0]   duty_w, tduty_w, up_sum, dn_dif;
    logic [PWM_W-1:0] ramp_val, dec_val;
    logic             drive;

    // One extra bit of headroom so stepping never wraps past either end.
    always_comb begin
        duty_w   = {1'b0, duty};
        tduty_w  = {1'b0, tduty};
        up_sum   = duty_w + STEP_W;
        dn_dif   = duty_w - STEP_W;
        ramp_val = duty;
        if (duty_w < tduty_w)
            ramp_val = (up_sum >= tduty_w) ? tduty : up_sum[PWM_W-1:0];
        else if (duty_w > tduty_w)
            ramp_val = (duty_w <= tduty_w + STEP_W) ? tduty : dn_dif[PWM_W-1:0];
        dec_val = (duty_w <= STEP_W) ? '0 : dn_dif[PWM_W-1:0];
        drive   = (pcnt < duty) && (st == ACTIVE || st == DECEL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            cdir     <= OFF;
            duty     <= '0;
            dead_cnt <= '0;
            fwd      <= 1'b0;
            rev      <= 1'b0;
        end else begin
            fwd <= en && drive && (cdir == FWD);
            rev <= en && drive && (cdir == REV);
            if (!en) begin
                st       <= IDLE;
                cdir     <= OFF;
                duty     <= '0;
                dead_cnt <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        duty <= '0;
                        if (tdir != OFF) begin
                            st   <= ACTIVE;
                            cdir <= dir_t'(tdir);
                        end
                    end
                    ACTIVE: begin
                        if (tdir != cdir) st <= DECEL;
                        else if (tick)    duty <= ramp_val;
                    end
                    DECEL: begin
                        if (tdir == cdir) begin
                            st <= ACTIVE;
                        end else if (duty == '0) begin
                            st       <= DEAD;
                            dead_cnt <= DEAD_LOAD;
                        end else if (tick) begin
                            duty <= dec_val;
                        end
                    end
                    DEAD: begin
                        dead_cnt <= dead_cnt - 1'b1;
                        if (dead_cnt == DW'(1)) begin
                            st   <= IDLE;
                            cdir <= OFF;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign state = st;

endmodule

// File: rtl/motor_drive_pwm.sv
// Two-motor H-bridge PWM driver: command decode, shared ramp prescaler and PWM counter.
// Motor A drives O1 (fwd) / O2 (rev); motor B drives O4 (fwd) / O3 (rev).
module motor_drive_pwm
    import motor_pkg::*;
#(
    parameter int PWM_W     = 8,
    parameter int RAMP_DIV  = 256,
    parameter int RAMP_STEP = 1,
    parameter int DEAD_CYC  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             F,
    input  logic             B,
    input  logic             L,
    input  logic             R,
    input  logic [PWM_W-1:0] speed,
    output logic             O1,
    output logic             O2,
    output logic             O3,
    output logic             O4,
    output logic             busy
);

    localparam int PW = $clog2(RAMP_DIV);

    cmd_t             cmd_q;
    logic [PW-1:0]    pre;
    logic [PWM_W-1:0] pcnt;
    logic             tick;
    dir_t             tdir_a, tdir_b;
    logic [1:0]       state_a, state_b;

    assign tick = (pre == PW'(RAMP_DIV - 1));

    always_comb begin
        tdir_a = OFF;
        tdir_b = OFF;
        if (speed != '0) begin
            case (cmd_q)
                FORWARD:  begin tdir_a = FWD; tdir_b = FWD; end
                BACKWARD: begin tdir_a = REV; tdir_b = REV; end
                LEFT:     tdir_b = FWD;
                RIGHT:    tdir_a = FWD;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q <= STOP;
            pre   <= '0;
            pcnt  <= '0;
            busy  <= 1'b0;
        end else begin
            cmd_q <= decode_cmd({F, B, L, R});
            pre   <= tick ? '0 : pre + 1'b1;
            pcnt  <= pcnt + 1'b1;
            busy  <= (state_a == DECEL) || (state_a == DEAD) ||
                     (state_b == DECEL) || (state_b == DEAD);
        end
    end

    motor_channel #(.PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP), .DEAD_CYC(DEAD_CYC)) u_ch_a (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .tdir(tdir_a), .tduty(speed),
        .pcnt(pcnt), .fwd(O1), .rev(O2), .state(state_a)
    );

    motor_channel #(.PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP), .DEAD_CYC(DEAD_CYC)) u_ch_b (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .tdir(tdir_b), .tduty(speed),
        .pcnt(pcnt), .fwd(O4), .rev(O3), .state(state_b)
    );

endmodule

// File: tb/tb_motor_drive_pwm.sv
// Directed bench for motor_drive_pwm with PWM_W=4, RAMP_DIV=4, RAMP_STEP=1, DEAD_CYC=8.
module tb_motor_drive_pwm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       F = 1'b0, B = 1'b0, L = 1'b0, R = 1'b0;
    logic [3:0] speed = '0;
    logic       O1, O2, O3, O4, busy;

    int errors  = 0;
    int checks  = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    motor_drive_pwm #(.PWM_W(4), .RAMP_DIV(4), .RAMP_STEP(1), .DEAD_CYC(8)) dut (
        .clk(clk), .rst(rst), .en(en), .F(F), .B(B), .L(L), .R(R), .speed(speed),
        .O1(O1), .O2(O2), .O3(O3), .O4(O4), .busy(busy)
    );

    always @(negedge clk)
        if ((O1 === 1'b1 && O2 === 1'b1) || (O3 === 1'b1 && O4 === 1'b1)) overlap++;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic f, input logic b, input logic l, input logic r,
                           input int spd);
        F = f; B = b; L = l; R = r;
        speed = 4'(spd);
    endtask

    // High-cycle counts of each pin and busy over n clocks, sampled on the falling edge.
    task automatic window(input int n, output int c1, output int c2, output int c3,
                          output int c4, output int cb);
        c1 = 0; c2 = 0; c3 = 0; c4 = 0; cb = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c1 += int'(O1 === 1'b1);
            c2 += int'(O2 === 1'b1);
            c3 += int'(O3 === 1'b1);
            c4 += int'(O4 === 1'b1);
            cb += int'(busy === 1'b1);
        end
    endtask

    task automatic wait_busy(input string tag, input logic val, input int lim);
        int n;
        n = 0;
        while (busy !== val && n < lim) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, int'(busy), int'(val));
    endtask

    initial begin
        int c1, c2, c3, c4, cb, n, rev_hi;

        repeat (2) @(negedge clk);
        check_eq("reset_O1", int'(O1), 0);
        check_eq("reset_O2", int'(O2), 0);
        check_eq("reset_O3", int'(O3), 0);
        check_eq("reset_O4", int'(O4), 0);
        check_eq("reset_busy", int'(busy), 0);

        // Forward ramp, then async reset while O1 is high
        rst = 1'b0;
        set_cmd(1, 0, 0, 0, 8);
        n = 0;
        while (O1 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("ramp_O1_seen", int'(O1), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_O1", int'(O1), 0);
        check_eq("async_rst_O4", int'(O4), 0);
        check_eq("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        window(16, c1, c2, c3, c4, cb);
        check_eq("restart_low_duty", int'(c1 <= 4), 1);
        window(50, c1, c2, c3, c4, cb);
        window(16, c1, c2, c3, c4, cb);
        check_eq("fwd_O1_8of16", c1, 8);
        check_eq("fwd_O4_8of16", c4, 8);
        check_eq("fwd_O2_zero", c2, 0);
        check_eq("fwd_O3_zero", c3, 0);

        // Reversal: 8 ticks of DECEL, 8 clocks dead, busy throughout
        set_cmd(0, 1, 0, 0, 8);
        wait_busy("rev_busy_rise", 1'b1, 10);
        n = 0;
        rev_hi = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (O2 === 1'b1 || O3 === 1'b1) rev_hi++;
            @(negedge clk);
        end
        check_eq("rev_busy_len_38_41", int'(n >= 38 && n <= 41), 1);
        check_eq("rev_pins_during_busy", rev_hi, 0);
        window(50, c1, c2, c3, c4, cb);
        window(16, c1, c2, c3, c4, cb);
        check_eq("bwd_O2_8of16", c2, 8);
        check_eq("bwd_O3_8of16", c3, 8);
        check_eq("bwd_O1_zero", c1, 0);
        check_eq("bwd_O4_zero", c4, 0);

        // Soft stop, then a non-one-hot command must stay stopped
        set_cmd(0, 0, 0, 0, 8);
        wait_busy("stop_busy_rise", 1'b1, 10);
        wait_busy("stop_busy_fall", 1'b0, 100);
        set_cmd(1, 1, 0, 0, 8);
        window(40, c1, c2, c3, c4, cb);
        check_eq("multihot_pins", c1 + c2 + c3 + c4, 0);
        check_eq("multihot_busy", cb, 0);

        // Left at full speed: only O4 drives
        set_cmd(0, 0, 1, 0, 15);
        window(80, c1, c2, c3, c4, cb);
        check_eq("left_ramp_A_B_rev", c1 + c2 + c3, 0);
        window(16, c1, c2, c3, c4, cb);
        check_eq("left_O4_15of16", c4, 15);
        check_eq("left_others", c1 + c2 + c3, 0);

        // Right: B decelerates while A ramps up from idle
        set_cmd(0, 0, 0, 1, 15);
        window(20, c1, c2, c3, c4, cb);
        window(16, c1, c2, c3, c4, cb);
        check_eq("right_A_ramping", int'(c1 > 0), 1);
        check_eq("right_B_decel", int'(c4 > 0), 1);
        check_eq("right_busy", cb, 16);
        check_eq("right_O3_zero", c3, 0);
        wait_busy("right_busy_fall", 1'b0, 100);
        window(16, c1, c2, c3, c4, cb);
        check_eq("right_O1_15of16", c1, 15);
        check_eq("right_O4_zero", c4, 0);

        // Speed retarget down on A stays ACTIVE (no busy)
        set_cmd(1, 0, 0, 0, 8);
        window(80, c1, c2, c3, c4, cb);
        check_eq("retarget_no_busy", cb, 0);
        window(16, c1, c2, c3, c4, cb);
        check_eq("retarget_O1_8of16", c1, 8);
        check_eq("retarget_O4_8of16", c4, 8);

        // Emergency stop: pins drop on the next edge, no dead phase
        en = 1'b0;
        @(posedge clk);
        #1;
        check_eq("estop_pins", int'(O1) + int'(O2) + int'(O3) + int'(O4), 0);
        window(12, c1, c2, c3, c4, cb);
        check_eq("estop_no_busy", cb, 0);
        check_eq("estop_pins_held", c1 + c2 + c3 + c4, 0);
        en = 1'b1;
        window(16, c1, c2, c3, c4, cb);
        check_eq("estop_restart_low", int'(c1 <= 4), 1);
        window(40, c1, c2, c3, c4, cb);
        window(16, c1, c2, c3, c4, cb);
        check_eq("estop_recover_O1", c1, 8);

        check_eq("no_fwd_rev_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
